// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit for the HI/LO registers: radix-2 Booth multiply and
// restoring divide, one step per clock. Define MULDIV_UNSIGNED_EN to add the is_unsigned port.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     acc_q, acc_d;   // Booth high half / partial remainder
  logic [WIDTH-1:0]   q_q, q_d;       // multiplier / dividend-then-quotient
  logic [WIDTH:0]     m_q, m_d;       // multiplicand (extended) / divisor magnitude
  logic               q1_q, q1_d;
  logic               div_q, div_d, uns_q, uns_d;
  logic               negq_q, negq_d, negr_q, negr_d;
  logic               dbz_q, dbz_d, done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               uns_i, a_neg, b_neg;
  logic [WIDTH:0]     sum, r_sh;
  logic [WIDTH+1:0]   trial;

`ifdef MULDIV_UNSIGNED_EN
  assign uns_i = is_unsigned;
`else
  assign uns_i = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    q1_d    = q1_q;
    div_d   = div_q;
    uns_d   = uns_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    a_neg   = !uns_i && a_in[WIDTH-1];
    b_neg   = !uns_i && b_in[WIDTH-1];
    sum     = acc_q;
    r_sh    = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial   = {1'b0, r_sh} - {1'b0, m_q};

    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          dbz_d  = op_div && (b_in == '0);
          div_d  = op_div;
          uns_d  = uns_i;
          acc_d  = '0;
          q1_d   = 1'b0;
          negq_d = op_div && (a_neg ^ b_neg);
          negr_d = op_div && a_neg;
          if (op_div) begin
            q_d = a_neg ? -a_in : a_in;
            m_d = {1'b0, (b_neg ? -b_in : b_in)};
          end else begin
            q_d = b_in;
            m_d = {(uns_i ? 1'b0 : a_in[WIDTH-1]), a_in};
          end
          // A zero divisor skips iterating but still passes through the counter-zero RUN cycle
          cnt_d   = (op_div && (b_in == '0)) ? '0 : CNT_W'(WIDTH);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (div_q) begin
            acc_d = trial[WIDTH+1] ? r_sh : trial[WIDTH:0];
            q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH+1]};
          end else begin
            if (uns_q) begin
              sum = q_q[0] ? acc_q + m_q : acc_q;
            end else begin
              case ({q_q[0], q1_q})
                2'b01:   sum = acc_q + m_q;
                2'b10:   sum = acc_q - m_q;
                default: sum = acc_q;
              endcase
            end
            acc_d = {(uns_q ? 1'b0 : sum[WIDTH]), sum[WIDTH:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            q1_d  = q_q[0];
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!dbz_q) begin
          if (div_q) begin
            lo_d = negq_q ? -q_q : q_q;
            hi_d = negr_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          end else begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = q_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      q1_q    <= 1'b0;
      div_q   <= 1'b0;
      uns_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      q1_q    <= q1_d;
      div_q   <= div_d;
      uns_q   <= uns_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed + randomized bench for muldiv_seq with a plain-arithmetic reference model.
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, op_div, uns;
  logic [W-1:0] a_in, b_in, hi_out, lo_out;
  logic         busy, done, div_by_zero;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;
  logic         exp_dbz = 1'b0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div),
    .a_in(a_in), .b_in(b_in),
`ifdef MULDIV_UNSIGNED_EN
    .is_unsigned(uns),
`endif
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: 64-bit integer arithmetic; SV '/' truncates toward zero, '%' follows the dividend
  task automatic model(input logic d, input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
    longint sa, sb, qq, rr;
    logic [63:0] p;
    if (d && b == '0) begin
      exp_dbz = 1'b1;
      return;
    end
    exp_dbz = 1'b0;
    if (!d) begin
      if (u) p = {32'b0, a} * {32'b0, b};
      else   p = longint'($signed(a)) * longint'($signed(b));
      exp_hi = W'(p >> W);
      exp_lo = W'(p);
    end else if (u) begin
      exp_lo = a / b;
      exp_hi = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      exp_lo = W'(qq);
      exp_hi = W'(rr);
    end
  endtask

  task automatic run_op(input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic u, input string tag);
    int n, lat;
    logic got;
    chk({tag, "_hold_hi"}, hi_out, exp_hi);
    chk({tag, "_hold_lo"}, lo_out, exp_lo);
    @(negedge clk);
    start = 1'b1; op_div = d; a_in = a; b_in = b; uns = u;
    @(posedge clk); #1;
    start = 1'b0; a_in = $urandom; b_in = $urandom;
    chk({tag, "_busy_up"}, busy, 1'b1);
    model(d, a, b, u);
    lat = (d && b == '0) ? 2 : W + 2;
    got = 1'b0;
    n = 0;
    for (int i = 1; i <= W + 10; i++) begin
      if (i == 4 && lat > 6) begin
        start = 1'b1; op_div = ~d; uns = ~u;
      end
      if (i == 5) start = 1'b0;
      @(posedge clk); #1;
      n = i;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_latency"}, got ? n : -1, lat);
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_hi"}, hi_out, exp_hi);
    chk({tag, "_lo"}, lo_out, exp_lo);
    chk({tag, "_dbz"}, div_by_zero, exp_dbz);
    // start during the done cycle must be ignored
    @(negedge clk);
    start = 1'b1; op_div = $urandom; a_in = $urandom; b_in = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_pulse"}, done, 1'b0);
    chk({tag, "_no_restart"}, busy, 1'b0);
  endtask

  initial begin
    logic d, u, saw_done;
    logic [W-1:0] a, b;
    reset = 1'b0; start = 1'b0; op_div = 1'b0; uns = 1'b0; a_in = '0; b_in = '0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", hi_out, '0);
    chk("rst_lo", lo_out, '0);
    chk("rst_dbz", div_by_zero, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op(1'b0, 32'd7, -32'sd3, 1'b0, "mul7x-3");
    chk("mul7x-3_hi_c", hi_out, 32'hFFFF_FFFF);
    chk("mul7x-3_lo_c", lo_out, 32'hFFFF_FFEB);
    run_op(1'b1, -32'sd7, 32'd2, 1'b0, "div-7/2");
    chk("div-7/2_lo_c", lo_out, 32'hFFFF_FFFD);
    chk("div-7/2_hi_c", hi_out, 32'hFFFF_FFFF);
    run_op(1'b1, 32'h0ACF_1234, 32'h2000, 1'b0, "prep1234");
    chk("prep_hi_c", hi_out, 32'h1234);
    chk("prep_lo_c", lo_out, 32'h5678);
    run_op(1'b1, 32'd5, 32'd0, 1'b0, "div5/0");
    chk("div5/0_hi_c", hi_out, 32'h1234);
    chk("div5/0_lo_c", lo_out, 32'h5678);
    chk("div5/0_dbz_c", div_by_zero, 1'b1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divminneg1");
    chk("divminneg1_lo_c", lo_out, 32'h8000_0000);
    chk("divminneg1_hi_c", hi_out, 32'h0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulminmin");
    chk("mulminmin_hi_c", hi_out, 32'h4000_0000);
    chk("mulminmin_lo_c", lo_out, 32'h0);

    // Reset in the middle of a multiply, after an ignored second start
    @(negedge clk);
    start = 1'b1; op_div = 1'b0; a_in = 32'h1234_5678; b_in = 32'h9ABC; uns = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) begin start = 1'b1; a_in = 32'd99; b_in = 32'd77; end
      if (i == 6) start = 1'b0;
      @(posedge clk); #1;
    end
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_hi", hi_out, '0);
    chk("midrst_lo", lo_out, '0);
    chk("midrst_dbz", div_by_zero, 1'b0);
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    saw_done = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", saw_done, 1'b0);
    run_op(1'b0, 32'd3, 32'd4, 1'b0, "mul3x4");
    chk("mul3x4_lo_c", lo_out, 32'd12);
    chk("mul3x4_hi_c", hi_out, 32'd0);

`ifdef MULDIV_UNSIGNED_EN
    run_op(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, "divu");
    chk("divu_lo_c", lo_out, 32'h7FFF_FFFF);
    chk("divu_hi_c", hi_out, 32'd1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, "multu");
    chk("multu_hi_c", hi_out, 32'd1);
    chk("multu_lo_c", lo_out, 32'hFFFF_FFFE);
`endif

    for (int k = 0; k < 40; k++) begin
      d = 1'(($urandom % 2));
      a = $urandom;
      b = $urandom;
      case ($urandom % 6)
        0: b = '0;
        1: b = W'(int'($urandom % 16) - 8);
        2: a = W'(int'($urandom % 64) - 32);
        default: ;
      endcase
`ifdef MULDIV_UNSIGNED_EN
      u = 1'(($urandom % 2));
`else
      u = 1'b0;
`endif
      run_op(d, a, b, u, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
